// File: rtl/fb_hazard_ctrl_pkg.sv
// Shared types and decision helpers for the pipeline hazard controller.
// The state encodings here (INIT=0, RUN=1, MEMWAIT=2, MCWAIT=3) are the
// single source of truth for the controller and for any debug tooling that
// decodes the state output.
package fb_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_MCWAIT  = 2'd3
  } state_e;

  // Number of cycles the controller holds the pipeline in INIT after reset.
  localparam int INIT_CYCLES = 2;

  // Pipeline register control bundle, one bit per output.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  // Everything frozen, both bubble inputs asserted.
  localparam ctrl_t CTRL_INIT = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                  exmem_we: 1'b0, ifid_flush: 1'b1,
                                  idex_flush: 1'b1};
  // Whole pipeline holds its contents.
  localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                    exmem_we: 1'b0, ifid_flush: 1'b0,
                                    idex_flush: 1'b0};
  // Taken branch: advance, but kill the two wrong-path instructions.
  localparam ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                   exmem_we: 1'b1, ifid_flush: 1'b1,
                                   idex_flush: 1'b1};
  // Load-use: hold PC and IF/ID, push one bubble into ID/EX.
  localparam ctrl_t CTRL_BUBBLE = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b1,
                                    exmem_we: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b1};
  // Free-flowing pipeline.
  localparam ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                    exmem_we: 1'b1, ifid_flush: 1'b0,
                                    idex_flush: 1'b0};

  typedef struct packed {
    ctrl_t  ctrl;
    state_e next;
    logic   flush_evt;
  } decision_t;

  // A load in EX whose destination feeds either ID source operand.
  // x0 never creates a dependency.
  function automatic logic load_use(input logic       id_valid,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2,
                                    input logic       mem_read,
                                    input logic [4:0] rd);
    return id_valid & mem_read & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
  endfunction

  // Priority decision applied whenever the pipeline is allowed to run:
  // memory stall, multi-cycle EX, taken branch, load-use, then normal flow.
  function automatic decision_t run_eval(input logic dmem_busy,
                                         input logic mc_busy,
                                         input logic branch_taken,
                                         input logic hazard);
    decision_t d;
    d.ctrl      = CTRL_NORMAL;
    d.next      = ST_RUN;
    d.flush_evt = 1'b0;
    if (dmem_busy) begin
      d.ctrl = CTRL_FREEZE;
      d.next = ST_MEMWAIT;
    end else if (mc_busy) begin
      d.ctrl = CTRL_FREEZE;
      d.next = ST_MCWAIT;
    end else if (branch_taken) begin
      d.ctrl      = CTRL_FLUSH;
      d.flush_evt = 1'b1;
    end else if (hazard) begin
      d.ctrl = CTRL_BUBBLE;
    end
    return d;
  endfunction

endpackage

// File: rtl/fb_hazard_ctrl_if.sv
// Hazard-status inputs from the pipeline and the register control outputs
// returned to it. The pipeline side is the master, the controller the slave.
interface fb_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_register_rs1;
  logic [4:0] id_register_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_register_rd;
  logic       ex_branch_taken;
  logic       ex_mc_busy;
  logic       dmem_busy;
  logic       pc_we;
  logic       ifid_we;
  logic       idex_we;
  logic       exmem_we;
  logic       ifid_flush;
  logic       idex_flush;

  modport master (
    output id_valid, id_register_rs1, id_register_rs2, ex_mem_read,
           ex_register_rd, ex_branch_taken, ex_mc_busy, dmem_busy,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush
  );

  modport slave (
    input  id_valid, id_register_rs1, id_register_rs2, ex_mem_read,
           ex_register_rd, ex_branch_taken, ex_mc_busy, dmem_busy,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush
  );
endinterface

// File: rtl/fb_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module fb_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Clear has priority over counting.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/fb_hazard_ctrl.sv
// Pipeline hazard controller: decides stall, bubble and flush for the
// pipeline registers each cycle (Mealy), tracks long memory waits with a
// sticky timeout, and counts stall and flush cycles.
module fb_hazard_ctrl
  import fb_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  fb_hazard_ctrl_if.slave  bus,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [1:0]        INIT_LAST  = 2'(INIT_CYCLES - 1);

  state_e            state_q;
  state_e            state_nxt;
  logic [1:0]        init_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              timeout_hit;
  logic              hazard;
  decision_t         dec;
  ctrl_t             ctrl;
  logic              flush_evt;
  logic              stall_evt;

  assign hazard = load_use(bus.id_valid, bus.id_register_rs1,
                           bus.id_register_rs2, bus.ex_mem_read,
                           bus.ex_register_rd);

  // Next-state and Mealy control outputs; reset forces the INIT response.
  always_comb begin
    dec       = run_eval(bus.dmem_busy, bus.ex_mc_busy, bus.ex_branch_taken,
                         hazard);
    ctrl      = CTRL_INIT;
    state_nxt = state_q;
    flush_evt = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ctrl      = dec.ctrl;
        state_nxt = dec.next;
        flush_evt = dec.flush_evt;
      end
      ST_MEMWAIT: begin
        if (bus.dmem_busy) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MEMWAIT;
        end else begin
          ctrl      = dec.ctrl;
          state_nxt = dec.next;
          flush_evt = dec.flush_evt;
        end
      end
      ST_MCWAIT: begin
        if (bus.dmem_busy) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MEMWAIT;
        end else if (bus.ex_mc_busy) begin
          ctrl      = CTRL_FREEZE;
          state_nxt = ST_MCWAIT;
        end else begin
          ctrl      = dec.ctrl;
          state_nxt = dec.next;
          flush_evt = dec.flush_evt;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
    if (rst) begin
      ctrl      = CTRL_INIT;
      state_nxt = ST_INIT;
      flush_evt = 1'b0;
    end
  end

  // Memory wait length: the cycle that enters MEMWAIT is the first busy
  // cycle, so entry restarts the count at one; it then saturates at the limit.
  always_comb begin
    wait_nxt    = wait_cnt;
    timeout_hit = 1'b0;
    if (!rst && state_nxt == ST_MEMWAIT) begin
      if (state_q != ST_MEMWAIT) begin
        wait_nxt = WAIT_W'(1);
      end else if (wait_cnt != WAIT_LIMIT) begin
        wait_nxt = wait_cnt + 1'b1;
      end
      timeout_hit = (wait_nxt == WAIT_LIMIT);
    end
  end

  // State register, INIT length counter, wait counter and sticky timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt    <= 2'd0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      init_cnt <= (state_q == ST_INIT) ? init_cnt + 2'd1 : 2'd0;
      wait_cnt <= wait_nxt;
      if (timeout_hit) mem_timeout <= 1'b1;
    end
  end

  assign stall_evt = !rst && (state_q != ST_INIT) && !ctrl.pc_we;

  fb_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_evt),
    .count (stall_cnt)
  );

  fb_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (flush_evt),
    .count (flush_cnt)
  );

  assign bus.pc_we      = ctrl.pc_we;
  assign bus.ifid_we    = ctrl.ifid_we;
  assign bus.idex_we    = ctrl.idex_we;
  assign bus.exmem_we   = ctrl.exmem_we;
  assign bus.ifid_flush = ctrl.ifid_flush;
  assign bus.idex_flush = ctrl.idex_flush;
  assign state          = state_q;

endmodule
